// File: rtl/axi_demux_1xn_burst.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with per-burst destination lock.
// Out-of-range destinations are sunk and counted; enable only gates the start of new bursts.
module axi_demux_1xn_burst #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_W   = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               enable,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_last,
    input  logic [SEL_W-1:0]   s_sel,
    output logic [NUM_OUT-1:0] m_valid,
    input  logic [NUM_OUT-1:0] m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_last,
    output logic               busy,
    output logic               dec_err,
    output logic [7:0]         err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               live_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   cur_sel;
    logic [NUM_OUT-1:0] dst_oh;
    logic               space;
    logic               drain;
    logic               sel_ok;
    logic               load;
    logic               first_err;

    // m_valid doubles as the buffer valid bit and one-hot destination
    assign drain  = |(m_valid & m_ready);
    assign space  = ~(|m_valid) | drain;
    assign sel_ok = 32'(s_sel) < NUM_OUT;

    // Next-state and handshake decode
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        load      = 1'b0;
        first_err = 1'b0;
        cur_sel   = sel_q;
        case (state_q)
            IDLE: begin
                cur_sel = s_sel;
                s_ready = live_q & enable & (sel_ok ? space : 1'b1);
                if (s_valid && s_ready) begin
                    if (sel_ok) begin
                        load = 1'b1;
                        if (!s_last) state_d = BURST;
                    end else begin
                        first_err = 1'b1;
                        if (!s_last) state_d = DROP;
                    end
                end
            end
            BURST: begin
                s_ready = space;
                if (s_valid && space) begin
                    load = 1'b1;
                    if (s_last) state_d = IDLE;
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dst_oh = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            dst_oh[i] = (32'(cur_sel) == i);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            sel_q     <= '0;
            m_valid   <= '0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            dec_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            busy    <= (state_d != IDLE);
            dec_err <= first_err;
            if (first_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (load && (state_q == IDLE)) sel_q <= s_sel;
            // Refill wins over drain so a same-cycle handoff leaves no bubble
            if (load) begin
                m_valid <= dst_oh;
                m_data  <= s_data;
                m_last  <= s_last;
            end else if (drain) begin
                m_valid <= '0;
                m_data  <= '0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_demux_1xn_burst.sv
// Directed and randomized bench for axi_demux_1xn_burst against a beat-level reference model.
module tb_axi_demux_1xn_burst;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned SEL_W   = 3;

    logic               ACLK = 1'b0;
    logic               ARESETN;
    logic               enable;
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic               s_last;
    logic [SEL_W-1:0]   s_sel;
    logic [NUM_OUT-1:0] m_valid;
    logic [NUM_OUT-1:0] m_ready;
    logic [DATA_W-1:0]  m_data;
    logic               m_last;
    logic               busy;
    logic               dec_err;
    logic [7:0]         err_count;

    axi_demux_1xn_burst #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .dec_err(dec_err), .err_count(err_count)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: lock = -1 no burst, -2 dropping, else locked output index
    int          lock;
    bit          mb_valid;
    int          mb_dst;
    logic [31:0] mb_data;
    bit          mb_last;
    int          merr;
    bit          mpulse;
    bit          mlive;
    bit          rnd_ready = 1'b0;
    int          hold_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        lock = -1; mb_valid = 0; mb_dst = 0; mb_data = '0; mb_last = 0;
        merr = 0; mpulse = 0; mlive = 0;
    endtask

    // One clock: entered at a falling edge with inputs driven, leaves at the next falling edge
    task automatic tick(output bit acc);
        logic [NUM_OUT-1:0] mr;
        logic [NUM_OUT-1:0] exp_mv;
        bit space, exp_sr, pulse_next;
        mr = rnd_ready ? NUM_OUT'($urandom) : '1;
        if (hold_cnt > 0) begin
            mr[1] = 1'b0;
            hold_cnt--;
        end
        m_ready = mr;
        #1;
        exp_mv = mb_valid ? NUM_OUT'(1 << mb_dst) : '0;
        space  = !mb_valid || m_ready[mb_dst];
        if (!mlive)          exp_sr = 0;
        else if (lock == -1) exp_sr = enable && ((s_sel >= NUM_OUT) || space);
        else if (lock == -2) exp_sr = 1;
        else                 exp_sr = space;
        chk("m_valid", 32'(m_valid), 32'(exp_mv));
        chk("m_data", m_data, mb_valid ? mb_data : 32'd0);
        chk("m_last", 32'(m_last), 32'(mb_valid && mb_last));
        chk("s_ready", 32'(s_ready), 32'(exp_sr));
        chk("busy", 32'(busy), 32'(lock != -1));
        chk("dec_err", 32'(dec_err), 32'(mpulse));
        chk("err_count", 32'(err_count), 32'(merr));
        acc = s_valid && exp_sr;
        if (!ARESETN) begin
            reset_model();
        end else begin
            pulse_next = 0;
            if (mb_valid && m_ready[mb_dst]) mb_valid = 0;
            if (acc) begin
                if (lock == -1 && s_sel >= NUM_OUT) begin
                    pulse_next = 1;
                    if (merr < 255) merr++;
                    lock = s_last ? -1 : -2;
                end else if (lock == -2) begin
                    if (s_last) lock = -1;
                end else begin
                    mb_valid = 1;
                    mb_dst   = (lock == -1) ? int'(s_sel) : lock;
                    mb_data  = s_data;
                    mb_last  = s_last;
                    lock     = s_last ? -1 : mb_dst;
                end
            end
            mpulse = pulse_next;
            mlive  = 1;
        end
        @(negedge ACLK);
    endtask

    task automatic idle(input int n);
        bit acc;
        s_valid = 0; s_last = 0;
        repeat (n) tick(acc);
    endtask

    // Offer one burst; beats are held until accepted
    task automatic send_burst(input int sel, input int len, input bit toggle,
                              input int en_off_after, input int gap_max);
        bit acc;
        for (int b = 0; b < len; b++) begin
            int waits;
            if (gap_max > 0) begin
                s_valid = 0;
                repeat ($urandom_range(0, gap_max)) tick(acc);
            end
            s_valid = 1; s_data = $urandom; s_last = (b == len - 1);
            if (b == 0) s_sel = SEL_W'(sel);
            waits = 0; acc = 0;
            while (!acc && waits < 64) begin
                tick(acc);
                waits++;
            end
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
            if (b == 0 && toggle) s_sel = ~s_sel;
            if (b == en_off_after) enable = 0;
        end
        s_valid = 0; s_last = 0;
    endtask

    initial begin
        bit acc;
        ARESETN = 0; enable = 1; s_valid = 1; s_data = 32'hDEAD_BEEF;
        s_last = 0; s_sel = 0; m_ready = '1;
        reset_model();
        @(negedge ACLK);

        // Reset held with s_valid asserted
        repeat (2) tick(acc);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        s_valid = 0;
        ARESETN = 1;
        tick(acc);
        chk("rel_s_ready", 32'(s_ready), 32'(enable));

        // 4-beat burst to output 2, s_sel scrambled after first beat
        send_burst(2, 4, 1, -1, 0);
        idle(2);

        // Back-to-back single-beat bursts
        send_burst(0, 1, 0, -1, 0);
        send_burst(1, 1, 0, -1, 0);
        send_burst(3, 1, 0, -1, 0);
        send_burst(2, 1, 0, -1, 0);
        idle(2);

        // Output 1 stalls for 3 cycles during its burst
        hold_cnt = 3;
        send_burst(1, 4, 0, -1, 0);
        idle(3);

        // Out-of-range bursts, then saturation of the error counter
        send_burst(5, 3, 0, -1, 0);
        idle(1);
        chk("err_one", 32'(err_count), 32'd1);
        for (int k = 0; k < 255; k++) send_burst(4 + (k % 4), 1, 0, -1, 0);
        idle(2);
        chk("err_sat", 32'(err_count), 32'd255);

        // enable drops after beat 1; the burst still completes
        send_burst(1, 4, 0, 1, 0);
        s_valid = 1; s_sel = 0; s_data = $urandom; s_last = 1;
        repeat (3) tick(acc);
        chk("en_blocked", 32'(s_ready), 32'd0);
        enable = 1;
        tick(acc);
        s_valid = 0; s_last = 0;
        idle(2);

        // Asynchronous reset in the middle of a burst
        s_valid = 1; s_sel = 3; s_data = $urandom; s_last = 0;
        tick(acc);
        tick(acc);
        #3;
        ARESETN = 0;
        reset_model();
        tick(acc);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        s_valid = 0;
        ARESETN = 1;
        idle(2);

        // Randomized bursts with random backpressure and valid gaps
        rnd_ready = 1;
        for (int k = 0; k < 200; k++) begin
            send_burst($urandom_range(0, 5), $urandom_range(1, 4), 1'($urandom), -1, 1);
        end
        rnd_ready = 0;
        idle(4);
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
